// File: rtl/line_pkg.sv
// Shared constants, state encoding and address helpers
// for the line-fill path.
package line_pkg;

    localparam int WORDS      = 32;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    localparam int LINE_OFF_W = $clog2(WORDS * WORD_BYTES);
    localparam int IDX_W      = $clog2(WORDS);
    localparam int CNT_W      = IDX_W + 1;
    localparam int WB_SH      = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    // Clear the in-line offset bits of a byte address.
    function automatic logic [ADDR_W-1:0] line_align(
        input logic [ADDR_W-1:0] a
    );
        logic [ADDR_W-1:0] m;
        m = '1;
        m = m << LINE_OFF_W;
        return a & m;
    endfunction

endpackage

// File: rtl/line_fill_sequencer_if.sv
// Word-wide memory port: request handshake plus
// in-order, non-backpressured read responses.
interface line_fill_sequencer_if;
    import line_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/line_word_addr.sv
// Byte address of word 'index' inside a line,
// wrapping modulo the address width.
module line_word_addr
    import line_pkg::*;
(
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [IDX_W-1:0]  index,
    output logic [ADDR_W-1:0] word_addr
);

    logic [ADDR_W-1:0] offset;

    assign offset    = ADDR_W'(index) << WB_SH;
    assign word_addr = line_addr + offset;

endmodule

// File: rtl/line_fill_sequencer.sv
// Fetches one aligned line word by word and collects
// the in-order responses into a flat line buffer.
module line_fill_sequencer
    import line_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    line_fill_sequencer_if.master   mem,
    output logic [ADDR_W-1:0]       line_addr,
    output logic [WORDS*DATA_W-1:0] line_data
);

    state_t                        state;
    logic [CNT_W-1:0]              req_cnt;
    logic [CNT_W-1:0]              rsp_cnt;
    logic [CNT_W-1:0]              req_nxt;
    logic [CNT_W-1:0]              rsp_nxt;
    logic                          req_valid_q;
    logic [ADDR_W-1:0]             req_addr_q;
    logic [ADDR_W-1:0]             nxt_addr;
    logic [ADDR_W-1:0]             base_line;
    logic [WORDS-1:0][DATA_W-1:0]  line_q;
    logic                          req_fire;
    logic                          rsp_take;
    logic                          rsp_bad;

    assign req_nxt   = req_cnt + CNT_W'(1);
    assign rsp_nxt   = rsp_cnt + CNT_W'(1);
    assign base_line = line_align(base_addr);
    assign req_fire  = req_valid_q & mem.req_ready;

    // A response with nothing outstanding is an
    // error in any state; the data is dropped.
    assign rsp_bad  = mem.rsp_valid
                    & (rsp_cnt == req_cnt);
    assign rsp_take = mem.rsp_valid
                    & (rsp_cnt < req_cnt)
                    & (state == FILL);

    line_word_addr u_addr (
        .line_addr (line_addr),
        .index     (req_nxt[IDX_W-1:0]),
        .word_addr (nxt_addr)
    );

    assign mem.req_valid = req_valid_q;
    assign mem.req_addr  = req_addr_q;
    assign line_data     = line_q;

    // Fill FSM with registered request/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            line_addr   <= '0;
            line_q      <= '0;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (rsp_bad) begin
                err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        line_addr   <= base_line;
                        req_addr_q  <= base_line;
                        req_valid_q <= 1'b1;
                        busy        <= 1'b1;
                        req_cnt     <= '0;
                        rsp_cnt     <= '0;
                        err         <= 1'b0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    // Address advances only on accept, so
                    // it is stable across stalls and never
                    // steps past the last word of the line.
                    if (req_fire) begin
                        req_cnt <= req_nxt;
                        if (req_nxt == CNT_W'(WORDS)) begin
                            req_valid_q <= 1'b0;
                        end else begin
                            req_addr_q <= nxt_addr;
                        end
                    end
                    if (rsp_take) begin
                        line_q[rsp_cnt[IDX_W-1:0]] <=
                            mem.rsp_data;
                        rsp_cnt <= rsp_nxt;
                        if (rsp_nxt == CNT_W'(WORDS)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_sequencer.sv
// Scoreboard bench: expected request addresses are
// queued at start and popped as requests are accepted.
module tb_line_fill_sequencer;
    import line_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       base_addr = '0;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [ADDR_W-1:0]       line_addr;
    logic [WORDS*DATA_W-1:0] line_data;

    line_fill_sequencer_if mem ();

    line_fill_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem       (mem),
        .line_addr (line_addr),
        .line_data (line_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_req  = 0;
    int n_done = 0;
    int lat    = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_line [WORDS];

    bit          stall  = 1'b0;
    bit          spur   = 1'b0;
    bit          pend_v = 1'b0;
    bit          held_v = 1'b0;
    logic [31:0] pend_a = '0;
    logic [31:0] held_a = '0;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h",
                     tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, then act as
    // a one-cycle-latency memory that echoes addresses.
    task automatic step();
        @(posedge clk);
        #1;
        if (done) n_done++;
        if (held_v) begin
            chk("req_hold_v", mem.req_valid, 1);
            chk("req_hold", mem.req_addr, held_a);
        end
        mem.rsp_valid = pend_v | spur;
        mem.rsp_data  = spur ? 32'hDEAD_BEEF : pend_a;
        mem.req_ready = stall ? ~mem.req_ready : 1'b1;
        pend_v = mem.req_valid & mem.req_ready;
        pend_a = mem.req_addr;
        held_v = mem.req_valid & ~mem.req_ready;
        held_a = mem.req_addr;
        if (pend_v) begin
            n_req++;
            if (exp_q.size() == 0)
                chk("req_extra", 1, 0);
            else
                chk("req_addr", mem.req_addr,
                    exp_q.pop_front());
        end
    endtask

    task automatic load_exp(input logic [31:0] la);
        exp_q.delete();
        for (int i = 0; i < WORDS; i++)
            exp_q.push_back(la + 32'(4 * i));
        n_req  = 0;
        n_done = 0;
    endtask

    task automatic run_fill(
        input logic [31:0] base,
        input bit          poke
    );
        logic [31:0] la;
        la = base & 32'hFFFF_FF80;
        load_exp(la);
        base_addr = base;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start", busy, 1);
        chk("reqv_start", mem.req_valid, 1);
        chk("req_addr0", mem.req_addr, la);
        chk("line_addr", line_addr, la);
        chk("err_clr", err, 0);
        lat = 0;
        for (int c = 0; c < 400 && n_done == 0; c++) begin
            if (poke && c == 4) begin
                start = 1'b1;
                base_addr = 32'h5555_0000;
            end
            step();
            start = 1'b0;
            lat = c + 2;
            if (poke && c == 4) begin
                chk("start_ignored", line_addr, la);
                chk("busy_held", busy, 1);
            end
        end
        if (n_done == 0) begin
            chk("timeout", 0, 1);
        end else begin
            if (!stall) chk("fill_lat", lat, WORDS + 2);
            chk("busy_done", busy, 1);
            for (int i = 0; i < WORDS; i++) begin
                exp_line[i] = la + 32'(4 * i);
                chk("word", line_data[i*DATA_W +: DATA_W],
                    exp_line[i]);
            end
            chk("n_req", n_req, WORDS);
            chk("q_empty", exp_q.size(), 0);
            step();
            chk("done_low", done, 0);
            chk("done_cnt", n_done, 1);
            chk("busy_clr", busy, 0);
            chk("reqv_idle", mem.req_valid, 0);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_reqv"}, mem.req_valid, 0);
        chk({tag, "_reqa"}, mem.req_addr, 0);
        chk({tag, "_laddr"}, line_addr, 0);
        chk({tag, "_ldata"}, 32'(|line_data), 0);
    endtask

    initial begin
        mem.req_ready = 1'b1;
        mem.rsp_valid = 1'b0;
        mem.rsp_data  = '0;

        step();
        step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        run_fill(32'h0000_1234, 1'b0);

        stall = 1'b1;
        run_fill(32'h0000_8A5C, 1'b0);
        stall = 1'b0;

        run_fill(32'hFFFF_FFF0, 1'b1);
        chk("wrap_laddr", line_addr, 32'hFFFF_FF80);
        chk("wrap_last", line_data[31*DATA_W +: DATA_W],
            32'hFFFF_FFFC);

        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        chk("spur_err", err, 1);
        chk("spur_busy", busy, 0);
        for (int i = 0; i < WORDS; i++)
            chk("spur_keep", line_data[i*DATA_W +: DATA_W],
                exp_line[i]);

        run_fill(32'h4000_0000, 1'b0);

        load_exp(32'h2000_0000);
        base_addr = 32'h2000_0044;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 100 && n_req < 10; c++) step();
        chk("pre_rst_nreq", n_req, 10);
        rst_n = 1'b0;
        step();
        chk_reset("abort");
        rst_n = 1'b1;
        exp_q.delete();
        step();
        chk("orphan_err", err, 1);

        run_fill(32'h2000_0044, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_chk, n_fail);
        $finish;
    end

endmodule
